// File: rtl/regfile_sb.sv
// Register file with per-entry busy scoreboard and a registered busy count.
// Optional write-to-read bypass is compiled in with REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rg_wrt_en,
  input  logic [ADDR_W-1:0] rg_wrt_addr,
  input  logic [DATA_W-1:0] rg_wrt_data,
  input  logic [ADDR_W-1:0] rg_rd_addr1,
  input  logic [ADDR_W-1:0] rg_rd_addr2,
  output logic [DATA_W-1:0] rg_rd_data1,
  output logic [DATA_W-1:0] rg_rd_data2,
  output logic              rg_rd_busy1,
  output logic              rg_rd_busy2,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  output logic [ADDR_W:0]   sb_busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] ONE = 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_cnt;

  logic              w_wr_ok, w_set_ok, w_inc, w_dec;
  logic [DATA_W-1:0] w_rd_data1, w_rd_data2;
  logic              w_rd_busy1, w_rd_busy2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign w_wr_ok  = rg_wrt_en && !is_zero(rg_wrt_addr);
  assign w_set_ok = sb_set_en && !is_zero(sb_set_addr);
  assign w_inc    = w_set_ok && !r_busy[sb_set_addr];
  // A clear on the same entry as a set is overridden, so it never decrements.
  assign w_dec    = w_wr_ok && r_busy[rg_wrt_addr] &&
                    !(w_set_ok && (sb_set_addr == rg_wrt_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[rg_wrt_addr]  <= rg_wrt_data;
        r_busy[rg_wrt_addr] <= 1'b0;
      end
      if (w_set_ok) r_busy[sb_set_addr] <= 1'b1;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + ONE;
        2'b01:   r_cnt <= r_cnt - ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    w_rd_data1 = is_zero(rg_rd_addr1) ? '0 : r_mem[rg_rd_addr1];
    w_rd_busy1 = !is_zero(rg_rd_addr1) && r_busy[rg_rd_addr1];
    w_rd_data2 = is_zero(rg_rd_addr2) ? '0 : r_mem[rg_rd_addr2];
    w_rd_busy2 = !is_zero(rg_rd_addr2) && r_busy[rg_rd_addr2];
`ifdef REGFILE_SB_BYPASS_EN
    // Same-cycle set never shows on the read busy; only the write path bypasses.
    if (w_wr_ok && (rg_rd_addr1 == rg_wrt_addr)) begin
      w_rd_data1 = rg_wrt_data;
      w_rd_busy1 = 1'b0;
    end
    if (w_wr_ok && (rg_rd_addr2 == rg_wrt_addr)) begin
      w_rd_data2 = rg_wrt_data;
      w_rd_busy2 = 1'b0;
    end
`endif
  end

  assign rg_rd_data1 = w_rd_data1;
  assign rg_rd_data2 = w_rd_data2;
  assign rg_rd_busy1 = w_rd_busy1;
  assign rg_rd_busy2 = w_rd_busy2;
  assign sb_busy_cnt = r_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected read/count tuples,
// a negedge monitor pops and compares whenever a check cycle is flagged.
module tb_regfile_sb;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;
  logic [4:0]  rg_rd_addr1, rg_rd_addr2;
  logic [31:0] rg_rd_data1, rg_rd_data2;
  logic        rg_rd_busy1, rg_rd_busy2;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic [5:0]  sb_busy_cnt;
  logic        chk;

  typedef struct {
    string       nm;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
    .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
    .rg_rd_data1(rg_rd_data1), .rg_rd_data2(rg_rd_data2),
    .rg_rd_busy1(rg_rd_busy1), .rg_rd_busy2(rg_rd_busy2),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .sb_busy_cnt(sb_busy_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_check: no expected entry queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rg_rd_data1 !== e.d1 || rg_rd_busy1 !== e.b1 ||
            rg_rd_data2 !== e.d2 || rg_rd_busy2 !== e.b2 ||
            sb_busy_cnt !== e.cnt) begin
          bad++;
          $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b cnt=%0d want d1=%h b1=%b d2=%h b2=%b cnt=%0d",
                   e.nm, rg_rd_data1, rg_rd_busy1, rg_rd_data2, rg_rd_busy2, sb_busy_cnt,
                   e.d1, e.b1, e.d2, e.b2, e.cnt);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic se, input logic [4:0] sa,
                     input logic [4:0] a1, input logic [4:0] a2, input logic rs);
    rg_wrt_en = we; rg_wrt_addr = wa; rg_wrt_data = wd;
    sb_set_en = se; sb_set_addr = sa;
    rg_rd_addr1 = a1; rg_rd_addr2 = a2;
    reset = rs;
    chk = 1'b0;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] d1, input logic b1,
                           input logic [31:0] d2, input logic b2, input logic [5:0] cnt);
    exp_t e;
    e.nm = nm; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.cnt = cnt;
    q.push_back(e);
    chk = 1'b1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    tick; tick;

    // reset state on every address
    for (int a = 0; a < 32; a += 2) begin
      cyc(0, 0, 0, 0, 0, 5'(a), 5'(a + 1), 0);
      expect_rd($sformatf("reset_rd_%0d", a), 0, 0, 0, 0, 0);
      tick;
    end

    // write/read and zero register
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0);
    expect_rd("wr5_same_cycle", BYP ? 32'hDEADBEEF : 32'h0, 0,
              BYP ? 32'hDEADBEEF : 32'h0, 0, 0);
    tick;
    cyc(1, 0, 32'h1234, 0, 0, 5, 5, 0);
    expect_rd("rd5_both", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
    tick;
    cyc(0, 0, 0, 0, 0, 0, 5, 0);
    expect_rd("zero_reg_wr", 0, 0, 32'hDEADBEEF, 0, 0);
    tick;

    // scoreboard set/clear counting
    cyc(0, 0, 0, 1, 3, 3, 7, 0); tick;
    cyc(0, 0, 0, 1, 7, 3, 7, 0);
    expect_rd("set3", 0, 1, 0, 0, 1);
    tick;
    cyc(0, 0, 0, 1, 3, 3, 7, 0);
    expect_rd("set7", 0, 1, 0, 1, 2);
    tick;
    cyc(1, 3, 32'h33, 0, 0, 3, 7, 0);
    expect_rd("reset3_again_wr3", BYP ? 32'h33 : 32'h0, !BYP, 0, 1, 2);
    tick;
    cyc(0, 0, 0, 0, 0, 3, 7, 0);
    expect_rd("after_wr3", 32'h33, 0, 0, 1, 1);
    tick;

    // set and write same non-busy address: set wins
    cyc(1, 9, 32'hA5A5A5A5, 1, 9, 9, 7, 0);
    expect_rd("set_wr9_cycle", BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0, 1, 1);
    tick;
    cyc(0, 0, 0, 1, 4, 9, 7, 0);
    expect_rd("after_set_wr9", 32'hA5A5A5A5, 1, 0, 1, 2);
    tick;

    // write busy entry while reading it
    cyc(1, 4, 32'hCAFEF00D, 0, 0, 4, 9, 0);
    expect_rd("wr4_busy_cycle", BYP ? 32'hCAFEF00D : 32'h0, !BYP, 32'hA5A5A5A5, 1, 3);
    tick;
    cyc(0, 0, 0, 0, 0, 4, 9, 0);
    expect_rd("after_wr4", 32'hCAFEF00D, 0, 32'hA5A5A5A5, 1, 2);
    tick;

    // set and clear on different entries in one cycle: net zero
    cyc(1, 7, 32'h77, 1, 10, 10, 7, 0);
    expect_rd("set10_wr7_cycle", 0, 0, BYP ? 32'h77 : 32'h0, !BYP, 2);
    tick;
    cyc(0, 0, 0, 1, 0, 10, 7, 0);
    expect_rd("after_set10_wr7", 0, 1, 32'h77, 0, 2);
    tick;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("set0_ignored", 0, 0, 0, 0, 2);
    tick;

    // saturate every entry, then a redundant set must not wrap
    for (int a = 1; a < 32; a++) begin
      cyc(0, 0, 0, 1, 5'(a), 0, 0, 0);
      tick;
    end
    cyc(0, 0, 0, 1, 5, 1, 31, 0);
    expect_rd("all_busy", 0, 1, 0, 1, 31);
    tick;
    cyc(0, 0, 0, 0, 0, 1, 31, 0);
    expect_rd("all_busy_resets", 0, 1, 0, 1, 31);
    tick;

    // reset dominates write and set in the same cycle
    cyc(1, 2, 32'h22, 1, 6, 2, 6, 1);
    expect_rd("reset_cycle", BYP ? 32'h22 : 32'h0, !BYP, 0, 1, 31);
    tick;
    cyc(0, 0, 0, 0, 0, 2, 6, 0);
    expect_rd("post_reset_2_6", 0, 0, 0, 0, 0);
    tick;
    cyc(0, 0, 0, 0, 0, 5, 9, 0);
    expect_rd("post_reset_5_9", 0, 0, 0, 0, 0);
    tick;

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) tick;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires entry 0 to zero and never marks it busy.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port rg_wrt_en, input, 1, the write enable.
REQ-007 The block SHALL have port rg_wrt_addr, input, ADDR_W, the write address.
REQ-008 The block SHALL have port rg_wrt_data, input, DATA_W, the write data.
REQ-009 The block SHALL have ports rg_rd_addr1 and rg_rd_addr2, input, ADDR_W, the read addresses.
REQ-010 The block SHALL have ports rg_rd_data1 and rg_rd_data2, output, DATA_W, the read data.
REQ-011 The block SHALL have ports rg_rd_busy1 and rg_rd_busy2, output, 1, meaning the addressed entry has a pending write.
REQ-012 The block SHALL have port sb_set_en, input, 1, which marks an entry busy (op issued).
REQ-013 The block SHALL have port sb_set_addr, input, ADDR_W, the entry to mark busy.
REQ-014 The block SHALL have port sb_busy_cnt, output, ADDR_W+1, the registered count of busy entries.

Function
REQ-015 Reads SHALL be combinational: rg_rd_dataN = entry[rg_rd_addrN] and rg_rd_busyN = busy[rg_rd_addrN], zero latency.
REQ-016 A write with rg_wrt_en=1 SHALL update entry[rg_wrt_addr] at the next rising clk edge.
REQ-017 A write SHALL clear busy[rg_wrt_addr] at the same edge.
REQ-018 sb_set_en=1 SHALL set busy[sb_set_addr] at the next edge.
REQ-019 When set and clear target the same address in one cycle, set SHALL win: entry written, busy stays 1.
REQ-020 When ZERO_REG=1: writes and sets to address 0 SHALL be ignored, rg_rd_dataN SHALL be 0 and rg_rd_busyN SHALL be 0 for address 0.
REQ-021 sb_busy_cnt SHALL equal the population count of busy[] after each edge: +1 for a set of a non-busy entry, -1 for a clear of a busy entry, net 0 when both occur on different entries in one cycle.
REQ-022 A set of an already-busy entry SHALL leave sb_busy_cnt unchanged; a write to a non-busy entry SHALL leave it unchanged.
REQ-023 sb_busy_cnt SHALL never wrap; maximum value is 2**ADDR_W (2**ADDR_W-1 when ZERO_REG=1).
REQ-024 Both read ports SHALL be independent and may address the same entry.

Reset
REQ-025 When reset=1 at a rising edge, all entries SHALL become 0, all busy bits 0 and sb_busy_cnt 0.
REQ-026 Reset SHALL dominate rg_wrt_en and sb_set_en asserted in the same cycle.
REQ-027 Reset SHALL take effect only on a clock edge; outputs during the reset cycle reflect the pre-reset state (or the bypass path, where compiled in).

Configuration
REQ-028 With macro REGFILE_SB_BYPASS_EN defined, a read whose address equals rg_wrt_addr while rg_wrt_en=1 (and address not 0 when ZERO_REG=1) SHALL return rg_wrt_data and busy=0 in the same cycle.
REQ-029 With REGFILE_SB_BYPASS_EN defined, a same-cycle sb_set_en to the read address SHALL NOT affect the combinational busy output.
REQ-030 Without REGFILE_SB_BYPASS_EN, reads SHALL return stored contents only; new data and busy clear become visible the cycle after the write.

Verification
REQ-031 Reset then read every address -> all rg_rd_data 0, all busy 0, sb_busy_cnt 0.
REQ-032 Write 0xDEADBEEF to addr 5, read addr 5 on both ports next cycle -> 0xDEADBEEF on both; write 0x1234 to addr 0 -> addr 0 reads 0.
REQ-033 Set addr 3, then addr 7, then addr 3 again -> busy3=busy7=1, sb_busy_cnt 1,2,2; write addr 3 -> busy3=0, cnt 1.
REQ-034 Same cycle: set addr 9 and write addr 9 with 0xA5A5A5A5 (addr 9 not busy) -> data 0xA5A5A5A5, busy9=1, cnt +1.
REQ-035 Write 0xCAFEF00D to busy addr 4 while reading addr 4 -> with REGFILE_SB_BYPASS_EN: 0xCAFEF00D and busy 0 in that cycle; without: old value and busy 1 in that cycle, new value and busy 0 next cycle.
REQ-036 Assert reset together with a write to addr 2 and a set of addr 6 -> next cycle addr 2 reads 0, busy6=0, cnt 0.
